// File: rtl/store_demux_pkg.sv
// store_demux_pkg: constants and types shared by the store-side demux and the
// load-side IO read mux.
//   - Region codes decoded from address bits [31:28]
//   - Full byte addresses of the memory-mapped IO registers
//   - UART one-entry transmit buffer state
//   - Region hit helpers used by the write-enable decode
package store_demux_pkg;

   localparam logic [3:0]  REGION_DMEM  = 4'b0001;
   localparam logic [3:0]  REGION_IMEM  = 4'b0010;
   localparam logic [3:0]  REGION_BOTH  = 4'b0011;
   localparam logic [3:0]  REGION_IO    = 4'b1000;

   localparam logic [31:0] ADDR_UART_TX = 32'h8000_0008;
   localparam logic [31:0] ADDR_CNT_RST = 32'h8000_0018;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   function automatic logic hits_dmem(input logic [3:0] region);
      return (region == REGION_DMEM) || (region == REGION_BOTH);
   endfunction

   function automatic logic hits_imem(input logic [3:0] region);
      return (region == REGION_IMEM) || (region == REGION_BOTH);
   endfunction

endpackage

// File: rtl/store_demux_uart_tx_buffer.sv
// uart_tx_buffer: one-entry holding register between the CPU store path and
// the UART transmitter.
//   clk, rst      : core clock, synchronous active-high reset
//   i_store       : a UART data store (valid, UART address, lane 0 enabled)
//   i_data        : byte carried by that store
//   i_ready       : transmitter takes the held byte at this edge
//   o_data        : held byte
//   o_valid       : buffer holds a byte
//   o_stall       : store cannot be taken this cycle
module uart_tx_buffer
   import store_demux_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_store,
   input  logic [7:0] i_data,
   input  logic       i_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_stall
);

   buf_state_e r_state;
   logic [7:0] r_data;

   // A full buffer that is draining this edge can take the new byte, so the
   // store only stalls when the transmitter is not ready.
   assign o_stall = i_store & (r_state == BUF_FULL) & ~i_ready;
   assign o_valid = (r_state == BUF_FULL);
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BUF_EMPTY;
         r_data  <= 8'h00;
      end else begin
         case (r_state)
            BUF_EMPTY: begin
               if (i_store) begin
                  r_data  <= i_data;
                  r_state <= BUF_FULL;
               end
            end
            BUF_FULL: begin
               if (i_ready) begin
                  if (i_store) begin
                     r_data <= i_data;
                  end else begin
                     r_state <= BUF_EMPTY;
                  end
               end
            end
            default: r_state <= BUF_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/store_demux.sv
// store_demux: decodes one CPU store onto DMEM, IMEM, the UART transmit buffer
// or the counter-reset register, and owns the cycle / retired-instruction
// counters read back by the load side.
//   clk, rst              : core clock, synchronous active-high reset
//   st_valid/addr/data/be : store request from the MEM stage (lane-aligned)
//   pc_bios               : store issued from BIOS; gates IMEM writes
//   instr_retire          : one instruction retires this cycle
//   dmem_we, imem_we      : byte write enables (same cycle as the store)
//   mem_addr, mem_din     : shared word address and data for DMEM/IMEM
//   uart_tx_*             : valid/ready byte stream toward the UART
//   stall                 : store not taken; CPU holds st_* next cycle
//   cycle_count           : free-running cycle counter
//   instr_count           : retired-instruction counter
module store_demux
   import store_demux_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [3:0]  st_be,
   input  logic        pc_bios,
   input  logic        instr_retire,
   output logic [3:0]  dmem_we,
   output logic [3:0]  imem_we,
   output logic [13:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   output logic        stall,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
);

   logic [3:0]  w_region;
   logic        w_uart_store;
   logic        w_cnt_rst;
   logic [31:0] r_cycle_count;
   logic [31:0] r_instr_count;

   assign w_region = st_addr[31:28];
   assign mem_addr = st_addr[15:2];
   assign mem_din  = st_data;

   // st_be = 0 yields zero enables naturally; no separate gate needed.
   assign dmem_we = (st_valid && hits_dmem(w_region)) ? st_be : 4'b0000;
   assign imem_we = (st_valid && hits_imem(w_region) && pc_bios) ? st_be : 4'b0000;

   // IO registers match on the full byte address; other IO offsets fall through.
   assign w_uart_store = st_valid && (st_addr == ADDR_UART_TX) && st_be[0];
   assign w_cnt_rst    = st_valid && (st_addr == ADDR_CNT_RST) && (st_be != 4'b0000);

   uart_tx_buffer u_uart_tx_buffer (
      .clk     (clk),
      .rst     (rst),
      .i_store (w_uart_store),
      .i_data  (st_data[7:0]),
      .i_ready (uart_tx_ready),
      .o_data  (uart_tx_data),
      .o_valid (uart_tx_valid),
      .o_stall (stall)
   );

   // Counter-reset store overrides that cycle's increment; both wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || w_cnt_rst) begin
         r_cycle_count <= 32'd0;
         r_instr_count <= 32'd0;
      end else begin
         r_cycle_count <= r_cycle_count + 32'd1;
         r_instr_count <= r_instr_count + {31'd0, instr_retire};
      end
   end

   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_store_demux.sv
module tb_store_demux;

   localparam logic [31:0] UART_A = 32'h8000_0008;
   localparam logic [31:0] CRST_A = 32'h8000_0018;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = 32'd0;
   logic [31:0] st_data = 32'd0;
   logic [3:0]  st_be = 4'd0;
   logic        pc_bios = 1'b0;
   logic        instr_retire = 1'b0;
   logic        uart_tx_ready = 1'b0;
   logic [3:0]  dmem_we, imem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_din;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        stall;
   logic [31:0] cycle_count, instr_count;

   store_demux dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr),
      .st_data(st_data), .st_be(st_be), .pc_bios(pc_bios),
      .instr_retire(instr_retire), .dmem_we(dmem_we), .imem_we(imem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .uart_tx_data(uart_tx_data),
      .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
      .stall(stall), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  dm;
      logic [3:0]  im;
      logic [13:0] ma;
      logic [31:0] md;
      logic        st;
      logic        uv;
      logic        ud_chk;
      logic [7:0]  ud;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   exp_t       q_exp[$];
   logic [7:0] q_uart[$];

   int checks = 0;
   int errors = 0;

   // Reference model state: "a byte is waiting for the transmitter" plus the
   // two counters as plain integers.
   logic        m_pending = 1'b0;
   logic        m_fresh   = 1'b1;
   logic [31:0] m_cycle   = 32'd0;
   logic [31:0] m_instr   = 32'd0;
   logic        last_stall = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply what the previous cycle's inputs do at the edge that just happened.
   task automatic model_edge();
      logic is_uart, is_crst, stl, consumed, accepted;
      if (rst) begin
         m_cycle = 0; m_instr = 0; m_pending = 0; m_fresh = 1;
         q_uart.delete();
         return;
      end
      is_crst = st_valid && st_addr == CRST_A && st_be != 0;
      if (is_crst) begin
         m_cycle = 0; m_instr = 0;
      end else begin
         m_cycle = m_cycle + 1;
         m_instr = m_instr + (instr_retire ? 1 : 0);
      end
      is_uart  = st_valid && st_addr == UART_A && st_be[0];
      stl      = is_uart && m_pending && !uart_tx_ready;
      consumed = m_pending && uart_tx_ready;
      accepted = is_uart && !stl;
      if (accepted) begin
         q_uart.push_back(st_data[7:0]);
         m_fresh = 0;
      end
      m_pending = (m_pending && !consumed) || accepted;
   endtask

   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic bios, input logic ret,
                       input logic rdy, input logic rs);
      exp_t e;
      logic [3:0] rg;
      @(posedge clk);
      model_edge();
      #1;
      st_valid = v; st_addr = a; st_data = d; st_be = be; pc_bios = bios;
      instr_retire = ret; uart_tx_ready = rdy; rst = rs;
      rg = a[31:28];
      e.dm = (v && (rg == 4'h1 || rg == 4'h3)) ? be : 4'h0;
      e.im = (v && bios && (rg == 4'h2 || rg == 4'h3)) ? be : 4'h0;
      e.ma = a[15:2];
      e.md = d;
      e.st = v && a == UART_A && be[0] && m_pending && !rdy;
      e.uv = m_pending;
      e.ud_chk = !m_pending && m_fresh;
      e.ud = 8'h00;
      e.cyc = m_cycle;
      e.ins = m_instr;
      last_stall = e.st;
      q_exp.push_back(e);
   endtask

   task automatic idle(input logic rdy, input logic ret);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, ret, rdy, 1'b0);
   endtask

   // Monitor: compares every presented cycle against the queued expectation
   // and every consumed UART byte against the accepted-byte stream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("dmem_we", {28'd0, dmem_we}, {28'd0, e.dm});
            chk("imem_we", {28'd0, imem_we}, {28'd0, e.im});
            chk("mem_addr", {18'd0, mem_addr}, {18'd0, e.ma});
            chk("mem_din", mem_din, e.md);
            chk("stall", {31'd0, stall}, {31'd0, e.st});
            chk("uart_tx_valid", {31'd0, uart_tx_valid}, {31'd0, e.uv});
            if (e.ud_chk) chk("uart_tx_data_reset", {24'd0, uart_tx_data}, {24'd0, e.ud});
            chk("cycle_count", cycle_count, e.cyc);
            chk("instr_count", instr_count, e.ins);
            if (uart_tx_valid && uart_tx_ready) begin
               if (q_uart.size() == 0) begin
                  chk("uart_unexpected_byte", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
               end else begin
                  chk("uart_byte", {24'd0, uart_tx_data}, {24'd0, q_uart.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  be;
      logic        v, bios, rdy, ret, rs;
      int          sel;

      // Reset
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 0);

      // DMEM and IMEM decode
      step(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, 0);
      step(1, 32'h3000_0010, 32'h1234_5678, 4'hF, 1, 0, 0, 0);
      step(1, 32'h3000_0010, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
      step(1, 32'h2000_0020, 32'h0, 4'h5, 1, 0, 0, 0);
      step(1, 32'h2000_0020, 32'h0, 4'h5, 0, 0, 0, 0);
      step(1, 32'h1000_0004, 32'h0, 4'h0, 1, 0, 0, 0);

      // UART stall then drain-and-refill
      step(1, UART_A, 32'h41, 4'h1, 0, 0, 0, 0);
      step(1, UART_A, 32'h42, 4'h1, 0, 0, 0, 0);
      step(1, UART_A, 32'h42, 4'h1, 0, 0, 0, 0);
      step(1, UART_A, 32'h42, 4'h1, 0, 0, 1, 0);
      idle(0, 0);
      idle(1, 0);
      idle(0, 0);

      // Back-to-back UART stores, transmitter always ready
      for (int i = 0; i < 5; i++) step(1, UART_A, 32'h60 + i, 4'h1, 0, 1, 1, 0);
      idle(1, 0);
      // UART address without lane 0, and other IO offsets, do nothing
      step(1, UART_A, 32'h77, 4'h2, 0, 0, 1, 0);
      step(1, 32'h8000_0010, 32'h77, 4'hF, 0, 0, 1, 0);

      // Counters over 100 cycles, 60 retiring
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 100; i++) idle(0, (i < 60));
      idle(0, 0);
      step(1, CRST_A, 0, 4'h8, 0, 1, 0, 0);
      idle(0, 1);
      idle(0, 0);
      step(1, CRST_A, 0, 4'h0, 0, 1, 0, 0);
      idle(0, 0);

      // Cycle counter wrap
      @(posedge clk);
      model_edge();
      #1;
      force dut.r_cycle_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycle_count;
      m_cycle = 32'hFFFF_FFFF;
      st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; instr_retire = 0;
      uart_tx_ready = 0; rst = 0; pc_bios = 0;
      begin
         exp_t e;
         e.dm = 0; e.im = 0; e.ma = 0; e.md = 0; e.st = 0; e.uv = m_pending;
         e.ud_chk = 0; e.ud = 0; e.cyc = m_cycle; e.ins = m_instr;
         q_exp.push_back(e);
      end
      idle(0, 0);
      idle(0, 0);

      // Reset while a byte is held and the transmitter is stalled
      step(1, UART_A, 32'h99, 4'h1, 0, 0, 0, 0);
      idle(0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 0);

      // Randomized traffic; a stalled store is held stable
      for (int n = 0; n < 600; n++) begin
         rdy = ($urandom_range(0, 2) != 0);
         ret = $urandom_range(0, 1);
         rs  = ($urandom_range(0, 99) == 0);
         if (last_stall) begin
            step(st_valid, st_addr, st_data, st_be, pc_bios, ret, rdy, rs);
         end else begin
            sel = $urandom_range(0, 15);
            d   = $urandom;
            be  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v   = ($urandom_range(0, 4) != 0);
            bios = $urandom_range(0, 1);
            case (sel)
               0, 1:    a = {4'h1, 28'($urandom)};
               2, 3:    a = {4'h2, 28'($urandom)};
               4, 5:    a = {4'h3, 28'($urandom)};
               6, 7, 8, 9, 10: a = UART_A;
               11:      a = CRST_A;
               12:      a = {4'h8, 24'd0, 4'($urandom_range(0, 7)) << 2};
               default: a = {4'($urandom_range(4, 7)), 28'($urandom)};
            endcase
            step(v, a, d, be, bios, ret, rdy, rs);
         end
      end

      // Drain
      for (int i = 0; i < 4; i++) idle(1, 0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", q_exp.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound on the whole run.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/store_demux.md
# store_demux

Store-path demultiplexer for the RISC-V core's memory stage, the write-side counterpart of the load/writeback select muxes. It decodes one CPU store (address, data, byte enables) onto DMEM, IMEM, the UART transmit port, or the counter-reset register. It also owns the cycle and retired-instruction counters, which the load side reads back. It sits between the MEM stage and the memories/IO, and raises a stall when the UART transmit buffer cannot accept a store.

## Interface
- No parameters; data 32 bits, byte-enable 4 bits, memory word address 14 bits (fixed).
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request present this cycle
- st_addr  in  32  byte address of store
- st_data  in  32  store data, already lane-aligned
- st_be  in  4  byte enables, already lane-aligned
- pc_bios  in  1  PC of the store instruction has bit 30 set (executing from BIOS)
- instr_retire  in  1  one instruction retires this cycle
- dmem_we  out  4  DMEM byte write enables
- imem_we  out  4  IMEM byte write enables
- mem_addr  out  14  st_addr[15:2], shared by DMEM and IMEM
- mem_din  out  32  st_data, shared by DMEM and IMEM
- uart_tx_data  out  8  byte offered to UART transmitter
- uart_tx_valid  out  1  uart_tx_data is valid
- uart_tx_ready  in  1  UART transmitter accepts byte this cycle
- stall  out  1  store not accepted; CPU holds st_* stable next cycle
- cycle_count  out  32  free-running cycle counter
- instr_count  out  32  retired-instruction counter

## Operation
- Region decode on st_addr[31:28]:
  - 4'b0001: DMEM.
  - 4'b0010: IMEM.
  - 4'b0011: DMEM and IMEM.
  - 4'b1000: IO.
  - Anything else: unmapped.
- dmem_we = st_be when st_valid and the region hits DMEM, else 0. Combinational; BRAM writes at the next edge.
- imem_we = st_be when st_valid, the region hits IMEM, and pc_bios = 1, else 0. An IMEM store with pc_bios = 0 is silently dropped.
- IO offsets:
  - 0x80000008: UART TX data, uses st_data[7:0]; requires st_be[0].
  - 0x80000018: counter reset; any nonzero st_be.
  - All other IO addresses are ignored.
- A store with st_be = 0 has no effect anywhere.
- UART buffer FSM, one entry, states EMPTY and FULL:
  - uart_tx_valid = (state == FULL).
  - EMPTY, UART store arrives: load byte, go to FULL.
  - FULL, uart_tx_ready = 1, no UART store: go to EMPTY.
  - FULL, uart_tx_ready = 1, UART store arrives: load new byte, stay FULL (drain and refill in the same cycle).
  - FULL, uart_tx_ready = 0, UART store arrives: stall = 1, nothing loaded.
- stall = st_valid & UART address & st_be[0] & FULL & ~uart_tx_ready. Combinational. Never asserted for any other address.
- Counters:
  - cycle_count increments by 1 every cycle.
  - instr_count increments by 1 when instr_retire = 1.
  - Both wrap 0xFFFFFFFF -> 0.
  - A counter-reset store sets both to 0 at the next edge; this overrides that cycle's increment.

## Timing
- Reset values: buffer EMPTY; uart_tx_valid = 0; uart_tx_data = 0; cycle_count = 0; instr_count = 0.
- Reset mid-transfer discards any buffered byte.
- rst has priority over every other update.
- Memory write enables: zero latency (same cycle as st_valid).
- UART byte: uart_tx_valid rises one cycle after the accepted store. uart_tx_data holds stable while FULL and uart_tx_ready = 0.
- Counter-reset store in cycle N: both counters read 0 in cycle N+1 and 1 (cycle) in N+2.
- stall depends only on current inputs and state; st_* must remain stable while stall = 1.

## Structure
- Shared package:
  - Region codes: REGION_DMEM, REGION_IMEM, REGION_BOTH, REGION_IO.
  - IO addresses: ADDR_UART_TX, ADDR_CNT_RST.
  - Buffer state enum.
  - The same constants are reused by the load-side IO read mux.
- One sub-module, uart_tx_buffer: the one-entry EMPTY/FULL holding register with the valid/ready handshake and the stall term.
- Decode and counters stay in store_demux.

## Test plan
- Store 0x10000004, data 0xDEADBEEF, be 4'b0011 -> dmem_we = 4'b0011, mem_addr = 1, imem_we = 0, stall = 0.
- Store 0x30000010, be 4'hF: with pc_bios = 1 -> dmem_we = imem_we = 4'hF, mem_addr = 4; with pc_bios = 0 -> imem_we = 0, dmem_we = 4'hF.
- UART store 0x41 with uart_tx_ready = 0, then second store 0x42 -> uart_tx_valid = 1 with data 0x41, stall = 1 on the second store. Raise ready -> 0x41 consumed, 0x42 loaded the same cycle, stall drops.
- Back-to-back UART stores with uart_tx_ready held 1 -> no stall; bytes appear in order one per cycle.
- Counter check:
  - After reset, run 100 cycles with instr_retire on 60 of them -> cycle_count = 100, instr_count = 60.
  - Counter-reset store -> both 0 next cycle.
  - Force cycle_count to 0xFFFFFFFF -> wraps to 0.
- Assert rst while FULL with ready = 0 -> next cycle uart_tx_valid = 0, counters = 0.
